exp_req_ctrl: RTL and testbench
===============================

EXP_REQ_CTRL -- requirements
Module: exp_req_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per request line (min 2).
REQ-002 SHALL have parameter LOST_W, default 8, width of lost-event counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port irq_in  in  3  asynchronous device request lines; bit 0 highest priority.
REQ-006 SHALL have port has_exp  in  1  CP0 exception-taken acknowledge, sampled at clk rising edge.
REQ-007 SHALL have port eret  in  1  eret instruction retiring this cycle, sampled at clk rising edge.
REQ-008 SHALL have port exp_src  out  3  one-hot request to CP0 exception sources 0..2, registered.
REQ-009 SHALL have port in_service  out  3  sources currently being serviced.
REQ-010 SHALL have port pending  out  3  latched, not-yet-acknowledged events.
REQ-011 SHALL have port lost_cnt  out  LOST_W  saturating count of events dropped.
REQ-012 SHALL have port busy  out  1  high when FSM not IDLE.

Function
REQ-013 SHALL pass each irq_in bit through SYNC_STAGES flops, then a rising-edge detector.
REQ-014 SHALL set pending[i] on a detected edge; an irq_in rise meeting setup before edge k sets pending at edge k+SYNC_STAGES+1.
REQ-015 SHALL count a lost event (lost_cnt+1, saturating at all-ones) when an edge arrives while pending[i] is already set and not being acknowledged that cycle.
REQ-016 SHALL treat source i as eligible when pending[i]=1 and in_service[j]=0 for all j<=i.
REQ-017 SHALL implement states IDLE, REQ, SVC.
REQ-018 IDLE: exp_src=0; any eligible source -> REQ, latching exp_src to the one-hot of the lowest-index eligible source.
REQ-019 REQ: exp_src SHALL stay constant until has_exp, even if a higher-priority source becomes eligible.
REQ-020 REQ with has_exp: set in_service for the exp_src bit, clear that pending bit, drive exp_src=0, go to SVC.
REQ-021 SVC: an eligible source (necessarily higher priority, i.e. nesting) -> REQ, latched as in REQ-018.
REQ-022 SVC with eret: clear the lowest-index set in_service bit; if none remain and none eligible -> IDLE, else remain SVC or go to REQ per REQ-021 on the next evaluation.
REQ-023 Same-cycle eret and has_exp: eret clear applied first, then has_exp set; both take effect.
REQ-024 Same-cycle edge and has_exp on the same source: pending stays 1 (new event); no loss counted.
REQ-025 has_exp in IDLE or SVC, and eret with in_service=0, SHALL be ignored with no state change.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 rst SHALL clear all synchronizer and edge flops, pending, in_service, exp_src, and lost_cnt; state = IDLE; busy=0.
REQ-028 rst mid-operation SHALL abandon any REQ/SVC; an irq_in held high through reset SHALL NOT generate an event until it falls and rises again.

Structure
REQ-029 Package exp_pkg SHALL hold NUM_SRC=3 and the state enum {IDLE, REQ, SVC}.
REQ-030 Sub-module sync_edge (SYNC_STAGES synchronizer plus rising-edge pulse) SHALL be instantiated once per source.

Verification
REQ-031 irq_in=3'b010 rises before edge 0 -> pending=010 at edge 3, exp_src=010 at edge 4; has_exp at edge 6 -> in_service=010, exp_src=000.
REQ-032 In SVC on source 2, irq_in[0] pulse -> exp_src=001; has_exp -> in_service=101; eret -> in_service=100, state SVC; eret -> in_service=000, IDLE.
REQ-033 In SVC on source 0, irq_in[2] pulse -> pending=100, exp_src stays 000 until eret, then exp_src=100.
REQ-034 Three rising pulses on irq_in[1] with no has_exp -> pending=010, lost_cnt=2; 300 pulses with LOST_W=8 -> lost_cnt=255.
REQ-035 Same-cycle eret and has_exp in SVC(source 1) with exp_src=001 -> in_service=001 afterwards.
REQ-036 rst asserted in REQ with irq_in=111 held -> all outputs 0; no exp_src until an irq_in bit falls and rises.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared constants, FSM state type and bit helpers for the exception
// request controller.
package exp_pkg;

  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  // Isolates the lowest-index set bit (index 0 is the highest priority).
  function automatic logic [NUM_SRC-1:0] lowest_one(input logic [NUM_SRC-1:0] v);
    return v & (~v + 1'b1);
  endfunction

endpackage

// File: rtl/exp_req_ctrl_if.sv
// Handshake between the request controller (master) and CP0 (slave).
interface exp_req_ctrl_if;
  import exp_pkg::*;

  logic               has_exp;
  logic               eret;
  logic [NUM_SRC-1:0] exp_src;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] pending;
  logic               busy;

  modport master (
    input  has_exp, eret,
    output exp_src, in_service, pending, busy
  );

  modport slave (
    output has_exp, eret,
    input  exp_src, in_service, pending, busy
  );
endinterface

// File: rtl/exp_req_ctrl_sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge pulse.
// A line that is already high when reset releases is not reported until
// it has been observed low at least once.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;  // marks when sync_q holds real samples
  logic                   prev_q;
  logic                   armed_q; // set once the line has been seen low

  // Synchronizer chain, arming and edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= sync_q[SYNC_STAGES-1];
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
      rise    <= sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;
    end
  end

endmodule

// File: rtl/exp_req_ctrl.sv
// Prioritised, nesting-aware exception request controller: latches device
// edges as pending events, presents one request at a time to CP0 and
// tracks which sources are being serviced until their eret.
module exp_req_ctrl
  import exp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOST_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  exp_req_ctrl_if.master     bus,
  output logic [LOST_W-1:0]  lost_cnt
);

  state_t             state_q, state_n;
  logic [NUM_SRC-1:0] exp_src_q, exp_src_n;
  logic [NUM_SRC-1:0] in_svc_q, in_svc_n;
  logic [NUM_SRC-1:0] pending_q, pending_n;
  logic [NUM_SRC-1:0] rise, elig, ack, lost_vec;
  logic [LOST_W:0]    lost_sum;
  logic [1:0]         n_lost;
  logic               blocked;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .async_in (irq_in[i]),
      .rise     (rise[i])
    );
  end

  // Next-state, request latching, service tracking and pending/loss update.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state_q;
    exp_src_n = exp_src_q;
    in_svc_n  = in_svc_q;
    ack       = '0;
    elig      = '0;
    blocked   = 1'b0;

    // A source is eligible only if nothing of equal or higher priority is
    // already in service.
    for (int i = 0; i < NUM_SRC; i++) begin
      blocked = blocked | in_svc_q[i];
      elig[i] = pending_q[i] & ~blocked;
    end

    // eret retires the innermost (highest-priority) nested service first;
    // with nothing in service this leaves in_svc_n unchanged.
    if (bus.eret) in_svc_n = in_svc_q & ~lowest_one(in_svc_q);

    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_n   = REQ;
          exp_src_n = lowest_one(elig);
        end
      end
      REQ: begin
        // The presented request is frozen until CP0 takes it.
        if (bus.has_exp) begin
          ack       = exp_src_q;
          in_svc_n  = in_svc_n | exp_src_q;
          exp_src_n = '0;
          state_n   = SVC;
        end
      end
      SVC: begin
        if (|elig) begin
          state_n   = REQ;
          exp_src_n = lowest_one(elig);
        end else if (bus.eret && in_svc_n == '0) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        exp_src_n = '0;
        in_svc_n  = '0;
      end
    endcase

    // A new edge wins over a same-cycle acknowledge, keeping the event.
    pending_n = (pending_q & ~ack) | rise;
    lost_vec  = rise & pending_q & ~ack;
    n_lost    = 2'($countones(lost_vec));
    lost_sum  = {1'b0, lost_cnt} + {{(LOST_W-1){1'b0}}, n_lost};
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_src_q <= '0;
      in_svc_q  <= '0;
      pending_q <= '0;
      lost_cnt  <= '0;
    end else begin
      state_q   <= state_n;
      exp_src_q <= exp_src_n;
      in_svc_q  <= in_svc_n;
      pending_q <= pending_n;
      lost_cnt  <= lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];
    end
  end

  assign bus.exp_src    = exp_src_q;
  assign bus.in_service = in_svc_q;
  assign bus.pending    = pending_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_exp_req_ctrl.sv
// Directed self-checking bench for exp_req_ctrl; expected requests are
// queued when stimulus is applied and compared when exp_src goes active.
module tb_exp_req_ctrl;
  import exp_pkg::*;

  localparam int LOST_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        irq_in;
  logic [LOST_W-1:0] lost_cnt;

  exp_req_ctrl_if bus();

  exp_req_ctrl #(.SYNC_STAGES(2), .LOST_W(LOST_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .bus      (bus),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  int         test_cnt = 0;
  int         fail_cnt = 0;
  logic [2:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    test_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge, where outputs are stable.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [2:0] exp_v;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      check(tag, 32'(bus.exp_src), 32'(exp_v));
    end
  endtask

  // Bounded wait for a request to appear, then compare with the scoreboard.
  task automatic wait_req(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (bus.exp_src !== 3'b000) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    pop_check(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_in = '0; bus.has_exp = 1'b0; bus.eret = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic pulse_irq(input int idx);
    irq_in[idx] = 1'b1; tick(1);
    irq_in[idx] = 1'b0; tick(2);
  endtask

  task automatic pulse_has_exp();
    bus.has_exp = 1'b1; tick(1); bus.has_exp = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
  endtask

  initial begin
    // Reset state, sampled while reset is still asserted.
    rst = 1'b1; irq_in = '0; bus.has_exp = 1'b0; bus.eret = 1'b0;
    tick(3);
    check("rst_exp_src", 32'(bus.exp_src), 32'd0);
    check("rst_in_service", 32'(bus.in_service), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_lost", 32'(lost_cnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Exact latency: rise before edge 0, pending at 3, request at 4, ack at 6.
    do_reset();
    irq_in = 3'b010;
    sb_q.push_back(3'b010);
    tick(3); // edges 0..2
    check("lat_pending_e2", 32'(bus.pending), 32'd0);
    tick(1); // edge 3
    check("lat_pending_e3", 32'(bus.pending), 32'b010);
    check("lat_exp_src_e3", 32'(bus.exp_src), 32'd0);
    tick(1); // edge 4
    pop_check("lat_exp_src_e4");
    check("lat_busy_e4", 32'(bus.busy), 32'd1);
    tick(1); // edge 5
    bus.has_exp = 1'b1;
    tick(1); // edge 6
    bus.has_exp = 1'b0;
    check("lat_in_service_e6", 32'(bus.in_service), 32'b010);
    check("lat_exp_src_e6", 32'(bus.exp_src), 32'd0);
    check("lat_pending_e6", 32'(bus.pending), 32'd0);
    irq_in = '0;
    pulse_eret();
    check("lat_eret_in_service", 32'(bus.in_service), 32'd0);
    check("lat_eret_busy", 32'(bus.busy), 32'd0);

    // Nesting: source 0 preempts service of source 2.
    do_reset();
    sb_q.push_back(3'b100);
    pulse_irq(2);
    wait_req("nest_req2");
    pulse_has_exp();
    check("nest_svc2", 32'(bus.in_service), 32'b100);
    sb_q.push_back(3'b001);
    pulse_irq(0);
    wait_req("nest_req0");
    pulse_has_exp();
    check("nest_svc20", 32'(bus.in_service), 32'b101);
    check("nest_exp_src_clr", 32'(bus.exp_src), 32'd0);
    pulse_eret();
    check("nest_eret1_svc", 32'(bus.in_service), 32'b100);
    check("nest_eret1_busy", 32'(bus.busy), 32'd1);
    pulse_eret();
    check("nest_eret2_svc", 32'(bus.in_service), 32'd0);
    check("nest_eret2_busy", 32'(bus.busy), 32'd0);

    // Lower priority event waits for the higher-priority service to end.
    do_reset();
    sb_q.push_back(3'b001);
    pulse_irq(0);
    wait_req("defer_req0");
    pulse_has_exp();
    check("defer_svc0", 32'(bus.in_service), 32'b001);
    pulse_irq(2);
    tick(4);
    check("defer_pending", 32'(bus.pending), 32'b100);
    check("defer_exp_src_held", 32'(bus.exp_src), 32'd0);
    sb_q.push_back(3'b100);
    pulse_eret();
    check("defer_exp_src_at_eret", 32'(bus.exp_src), 32'd0);
    wait_req("defer_req2");

    // Lost events and saturation.
    do_reset();
    for (int i = 0; i < 3; i++) pulse_irq(1);
    tick(4);
    check("lost_pending", 32'(bus.pending), 32'b010);
    check("lost_cnt_2", 32'(lost_cnt), 32'd2);
    check("lost_exp_src", 32'(bus.exp_src), 32'b010);
    for (int i = 0; i < 297; i++) pulse_irq(1);
    tick(4);
    check("lost_cnt_sat", 32'(lost_cnt), 32'd255);

    // Same-cycle eret and has_exp while nesting over source 1.
    do_reset();
    sb_q.push_back(3'b010);
    pulse_irq(1);
    wait_req("same_req1");
    pulse_has_exp();
    sb_q.push_back(3'b001);
    pulse_irq(0);
    wait_req("same_req0");
    bus.has_exp = 1'b1; bus.eret = 1'b1;
    tick(1);
    bus.has_exp = 1'b0; bus.eret = 1'b0;
    check("same_in_service", 32'(bus.in_service), 32'b001);
    check("same_exp_src", 32'(bus.exp_src), 32'd0);
    check("same_busy", 32'(bus.busy), 32'd1);

    // Reset mid-request with all lines held high.
    do_reset();
    irq_in = 3'b111;
    sb_q.push_back(3'b001);
    wait_req("hold_req");
    rst = 1'b1;
    tick(2);
    check("hold_rst_exp_src", 32'(bus.exp_src), 32'd0);
    check("hold_rst_in_service", 32'(bus.in_service), 32'd0);
    check("hold_rst_pending", 32'(bus.pending), 32'd0);
    check("hold_rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick(10);
    check("hold_no_exp_src", 32'(bus.exp_src), 32'd0);
    check("hold_no_pending", 32'(bus.pending), 32'd0);
    irq_in[2] = 1'b0;
    tick(3);
    irq_in[2] = 1'b1;
    sb_q.push_back(3'b100);
    wait_req("hold_rearm");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
